// File: rtl/data_bank_refill_ram.sv
// Byte-writable L1 data bank with combinational forwarding read port and an AXI line-refill engine.
// Optional macro REFILL_CRITICAL_WORD_FIRST_EN: refill starts at the requested word and wraps the line.
module data_bank_refill_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int LINE_WORDS = 8
) (
    input  logic                  clka,
    input  logic                  resetn,
    input  logic [DATA_WIDTH/8-1:0] wea,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  refill_start,
    input  logic [ADDR_WIDTH-1:0] refill_addr,
    input  logic                  refill_valid,
    input  logic [DATA_WIDTH-1:0] refill_data,
    input  logic                  refill_last,
    output logic                  refill_ready,
    output logic                  refill_busy,
    output logic                  refill_done,
    output logic                  refill_err
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OW    = $clog2(LINE_WORDS);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [OW-1:0]         offset;
    logic [OW-1:0]         count;
    logic                  err_flag;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  hs;
    logic                  final_beat;
    logic                  last_bad;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [OW-1:0]         start_off;

    assign hs         = refill_valid & refill_ready;
    assign fill_addr  = base | ADDR_WIDTH'(offset);
    assign final_beat = (count == OW'(LINE_WORDS - 1));
    // RLAST must be high exactly on the beat that completes the line
    assign last_bad   = refill_last ^ final_beat;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign start_off = refill_addr[OW-1:0];
`else
    assign start_off = '0;
`endif

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            base         <= '0;
            offset       <= '0;
            count        <= '0;
            err_flag     <= 1'b0;
            refill_ready <= 1'b0;
            refill_busy  <= 1'b0;
            refill_done  <= 1'b0;
            refill_err   <= 1'b0;
        end else begin
            refill_done <= 1'b0;
            refill_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (refill_start) begin
                        state        <= FILL;
                        base         <= refill_addr & ~ADDR_WIDTH'(LINE_WORDS - 1);
                        offset       <= start_off;
                        count        <= '0;
                        err_flag     <= 1'b0;
                        refill_ready <= 1'b1;
                        refill_busy  <= 1'b1;
                    end
                end
                FILL: begin
                    if (hs) begin
                        offset <= offset + 1'b1;
                        count  <= count + 1'b1;
                        if (final_beat) begin
                            state        <= IDLE;
                            refill_ready <= 1'b0;
                            refill_busy  <= 1'b0;
                            refill_done  <= 1'b1;
                            refill_err   <= err_flag | last_bad;
                        end else if (last_bad) begin
                            err_flag <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store lanes are written after the refill word so they win on a collision
    always_ff @(posedge clka) begin
        if (hs)
            mem[fill_addr] <= refill_data;
        for (int i = 0; i < NB; i++)
            if (wea[i])
                mem[waddr][i*8 +: 8] <= dina[i*8 +: 8];
    end

    for (genvar i = 0; i < NB; i++) begin : g_rd_lane
        always_comb begin
            if (wea[i] && (waddr == raddr))
                douta[i*8 +: 8] = dina[i*8 +: 8];
            else if (hs && (fill_addr == raddr))
                douta[i*8 +: 8] = refill_data[i*8 +: 8];
            else
                douta[i*8 +: 8] = mem[raddr][i*8 +: 8];
        end
    end
endmodule

// File: tb/tb_data_bank_refill_ram.sv
// Bench for data_bank_refill_ram: directed vector table, refill sequences and a random run vs. a behavioural model.
module tb_data_bank_refill_ram;
    localparam int LW = 8;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    localparam int CWF = 1;
`else
    localparam int CWF = 0;
`endif

    logic        clka, resetn;
    logic [3:0]  wea;
    logic [6:0]  waddr, raddr, refill_addr;
    logic [31:0] dina, douta, refill_data;
    logic        refill_start, refill_valid, refill_last;
    logic        refill_ready, refill_busy, refill_done, refill_err;

    data_bank_refill_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .LINE_WORDS(LW)) dut (
        .clka(clka), .resetn(resetn), .wea(wea), .waddr(waddr), .dina(dina),
        .raddr(raddr), .douta(douta), .refill_start(refill_start),
        .refill_addr(refill_addr), .refill_valid(refill_valid),
        .refill_data(refill_data), .refill_last(refill_last),
        .refill_ready(refill_ready), .refill_busy(refill_busy),
        .refill_done(refill_done), .refill_err(refill_err)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int npass = 0, ntot = 0;

    // behavioural model: word array plus the ordered address list of the active line fill
    logic [31:0] exp_mem [128];
    bit m_busy = 0, m_flag = 0, m_done = 0, m_err = 0;
    int m_base = 0, m_st = 0, m_k = 0;

    typedef struct {
        logic [3:0]  wea;
        logic [6:0]  waddr;
        logic [31:0] dina;
        logic [6:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        else npass++;
    endtask

    function automatic int fill_word(input int k);
        return m_base + ((m_st + k) % LW);
    endfunction

    // one clock: compare every output against the model, then advance model at the edge
    task automatic tick();
        logic [31:0] ed;
        bit hs, fin, bad;
        int fa;
        #1;
        hs = refill_valid && m_busy;
        fa = fill_word(m_k);
        for (int i = 0; i < 4; i++) begin
            if (wea[i] && waddr == raddr)      ed[i*8 +: 8] = dina[i*8 +: 8];
            else if (hs && int'(raddr) == fa)  ed[i*8 +: 8] = refill_data[i*8 +: 8];
            else                               ed[i*8 +: 8] = exp_mem[raddr][i*8 +: 8];
        end
        chk("douta", douta, ed);
        chk("refill_ready", 32'(refill_ready), 32'(m_busy));
        chk("refill_busy", 32'(refill_busy), 32'(m_busy));
        chk("refill_done", 32'(refill_done), 32'(m_done));
        chk("refill_err", 32'(refill_err), 32'(m_err));
        @(posedge clka);
        if (hs && resetn) exp_mem[fa] = refill_data;
        for (int i = 0; i < 4; i++)
            if (wea[i]) exp_mem[waddr][i*8 +: 8] = dina[i*8 +: 8];
        m_done = 0;
        m_err  = 0;
        if (!resetn) begin
            m_busy = 0;
        end else if (hs) begin
            fin = (m_k == LW - 1);
            bad = (refill_last != fin);
            if (fin) begin
                m_busy = 0; m_done = 1; m_err = m_flag | bad;
            end else begin
                m_flag = m_flag | bad;
            end
            m_k++;
        end else if (!m_busy && refill_start) begin
            m_busy = 1;
            m_base = int'(refill_addr) & ~(LW - 1);
            m_st   = CWF ? int'(refill_addr) % LW : 0;
            m_k    = 0;
            m_flag = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        wea = 0; refill_start = 0; refill_valid = 0; refill_last = 0;
    endtask

    // full refill; done must appear exp_cyc cycles after the start cycle
    task automatic refill(input logic [6:0] a, input bit toggle, input int lastbeat,
                          input int exp_cyc, input bit exp_err);
        int beat = 0, cyc = 0;
        bit seen = 0, hs;
        refill_start = 1; refill_addr = a; refill_valid = 0;
        tick();
        refill_start = 0;
        while (!seen && cyc < 40) begin
            cyc++;
            refill_valid = toggle ? cyc[0] : 1'b1;
            refill_data  = 32'h100 + beat;
            refill_last  = (beat + 1 == lastbeat);
            raddr = (a & 7'h78) | 7'($urandom % LW);
            #1;
            hs = refill_valid & refill_ready;
            if (refill_done) begin
                seen = 1;
                chk("done_cycle", cyc, exp_cyc);
                chk("done_err", 32'(refill_err), 32'(exp_err));
            end
            tick();
            if (hs) beat++;
        end
        if (!seen) chk("refill_timeout", 0, 1);
        idle_inputs();
    endtask

    task automatic check_line(input int base, input int st, input int dbase);
        for (int j = 0; j < LW; j++) begin
            raddr = 7'(base + j);
            #1;
            chk($sformatf("line_word%0d", j), douta, 32'(dbase + ((j - st + LW) % LW)));
            tick();
        end
    endtask

    initial begin
        vt[0] = '{4'b0101, 7'd5, 32'hAABBCCDD, 7'd5, 32'h00BB00DD};
        vt[1] = '{4'b0000, 7'd0, 32'h0,        7'd5, 32'h00BB00DD};
        vt[2] = '{4'b1111, 7'd9, 32'h12345678, 7'd5, 32'h00BB00DD};
        vt[3] = '{4'b0010, 7'd9, 32'h0000AB00, 7'd9, 32'h1234AB78};
        vt[4] = '{4'b0000, 7'd0, 32'h0,        7'd9, 32'h1234AB78};
        vt[5] = '{4'b1000, 7'd5, 32'hFF000000, 7'd9, 32'h1234AB78};
        vt[6] = '{4'b0000, 7'd0, 32'h0,        7'd5, 32'hFFBB00DD};
        for (int i = 0; i < 128; i++) exp_mem[i] = 32'h0;

        // reset with outputs checked low
        resetn = 0; idle_inputs();
        refill_addr = 0; refill_data = 0; wea = 4'hF; waddr = 0; raddr = 0; dina = 0;
        #2;
        tick(); tick();
        resetn = 1;
        // zero the array so the model is fully defined
        for (int i = 0; i < 128; i++) begin
            wea = 4'hF; waddr = 7'(i); raddr = 7'(i); dina = 0;
            tick();
        end
        idle_inputs();

        foreach (vt[i]) begin
            wea = vt[i].wea; waddr = vt[i].waddr; dina = vt[i].dina; raddr = vt[i].raddr;
            #1;
            chk($sformatf("vec%0d", i), douta, vt[i].exp);
            tick();
        end
        idle_inputs();

        refill(7'h13, 0, 8, 9, 0);
        check_line(16, CWF ? 3 : 0, 32'h100);
        for (int i = 16; i < 24; i++) begin
            waddr = 7'(i); raddr = 7'(i); wea = 4'hF; dina = 0; tick();
        end
        wea = 0;
        refill(7'h13, 1, 8, 16, 0);
        check_line(16, CWF ? 3 : 0, 32'h100);
        refill(7'h45, 0, 3, 9, 1);
        check_line(64, CWF ? 5 : 0, 32'h100);

        // store into the word the refill writes in the same cycle
        refill_start = 1; refill_addr = 7'h10; tick();
        refill_start = 0;
        for (int k = 0; k < LW; k++) begin
            refill_valid = 1; refill_last = (k == LW - 1);
            refill_data = (k == 2) ? 32'h12345678 : 32'h200 + k;
            raddr = 7'h12;
            if (k == 2) begin
                wea = 4'b1000; waddr = 7'h12; dina = 32'hEE000000;
                #1;
                chk("collide_fwd", douta, 32'hEE345678);
            end
            tick();
            wea = 0;
        end
        refill_valid = 0;
        #1;
        chk("collide_done", 32'(refill_done), 1);
        tick();
        raddr = 7'h12;
        #1;
        chk("collide_word", douta, 32'hEE345678);
        tick();

        // reset in the middle of a fill
        refill_start = 1; refill_addr = 7'h20; tick();
        refill_start = 0; refill_valid = 1;
        for (int k = 0; k < 4; k++) begin
            refill_data = 32'h300 + k; refill_last = 0; tick();
        end
        resetn = 0; m_busy = 0; m_done = 0; m_err = 0;
        #1;
        chk("rst_busy", 32'(refill_busy), 0);
        chk("rst_ready", 32'(refill_ready), 0);
        tick(); tick();
        resetn = 1; idle_inputs();
        tick();
        refill(7'h20, 0, 8, 9, 0);
        check_line(32, 0, 32'h100);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            wea   = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
            waddr = ($urandom % 2) ? 7'(m_base + $urandom % LW) : 7'($urandom);
            dina  = $urandom;
            case ($urandom % 3)
                0: raddr = 7'($urandom);
                1: raddr = waddr;
                default: raddr = 7'(fill_word(m_k));
            endcase
            refill_start = ($urandom % 6 == 0);
            refill_addr  = 7'($urandom);
            refill_valid = ($urandom % 3 != 0);
            refill_data  = $urandom;
            refill_last  = (m_busy && m_k == LW - 1) ^ ($urandom % 8 == 0);
            tick();
        end
        idle_inputs();
        tick(); tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
